// File: rtl/uart_pkg.sv
// Shared definitions for the oversampled UART receiver.
//   DATA_BITS   : payload bits per frame (8N1 framing)
//   rx_state_e  : receiver FSM state encoding
//   div_reload  : reload value of the sample-tick divider
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } rx_state_e;

  // Clock cycles per sample tick, minus one. Clamped at 0 so that a clock slower
  // than one tick per cycle still produces a tick every cycle.
  function automatic int unsigned div_reload(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned os);
    int unsigned cycles;
    cycles = clk_hz / (baud * os);
    return (cycles == 0) ? 0 : cycles - 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO for the UART receiver.
//   clk, rst : clock, synchronous active-high reset (clears pointers)
//   push     : write wdata; ignored when full unless a pop happens the same cycle
//   wdata    : byte to store
//   pop      : remove head byte; ignored when empty
//   rdata    : head byte (combinational from storage), 0 while empty
//   full     : DEPTH bytes stored
//   empty    : no bytes stored
//   level    : occupancy, wr - rd modulo 2^(log2(DEPTH)+1)
// DEPTH must be a power of two and at least 2.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DATA_BITS-1:0]   wdata,
  input  logic                   pop,
  output logic [DATA_BITS-1:0]   rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = 1;

  logic [AW:0]          wr_q, rd_q;
  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic                 do_push, do_pop;

  // Pointers carry one extra wrap bit, so the difference is the occupancy and
  // its top bit is set exactly when the FIFO holds DEPTH entries.
  assign level   = wr_q - rd_q;
  assign empty   = (wr_q == rd_q);
  assign full    = level[AW];
  assign do_pop  = pop && !empty;
  // When full, the write slot equals the head slot; a simultaneous pop reads the
  // old head this cycle, so overwriting it at the edge is safe.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PtrOne;
      if (do_pop)  rd_q <= rd_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampling 8N1 UART receiver with an output byte FIFO.
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   rx           : asynchronous serial input, idle high
//   rx_valid     : FIFO holds at least one byte
//   rx_data      : FIFO head byte, valid while rx_valid
//   rx_ready     : consumer accepts the head byte (pop on rx_valid && rx_ready)
//   fifo_level   : FIFO occupancy
//   frame_error  : one-cycle pulse when a stop bit is sampled low
//   overrun      : one-cycle pulse when a received byte is dropped (FIFO full)
//   is_receiving : FSM is not idle
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKFRQ   = 48_000_000,
  parameter int unsigned BAUDRATE   = 3_000_000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx,
  output logic                        rx_valid,
  output logic [DATA_BITS-1:0]        rx_data,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        frame_error,
  output logic                        overrun,
  output logic                        is_receiving
);

  localparam int unsigned DivReload = div_reload(CLOCKFRQ, BAUDRATE, OVERSAMPLE);
  localparam int unsigned DivW      = (DivReload > 0) ? $clog2(DivReload + 1) : 1;
  localparam logic [DivW-1:0] DivInit = DivW'(DivReload);
  localparam logic [DivW-1:0] DivOne  = 1;

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] SampA    = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SampB    = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] SampC    = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] SampLast = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SampOne  = 1;

  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BitLast = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] BitOne  = 1;

  // Synchronizer
  logic sync1_q, sync2_q;
  logic rx_s;

  // Receiver state
  rx_state_e            state_q, state_d;
  logic [DivW-1:0]      div_q, div_d;
  logic [SW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 s0_q, s0_d, s1_q, s1_d;
  logic                 brk_q, brk_d;
  logic                 push_q, push_d;
  logic                 fe_q, fe_d;

  logic tick, decide, bit_end, maj;

  // FIFO side
  logic fifo_full, fifo_empty, pop;

  assign rx_s = sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  assign tick    = (div_q == '0);
  assign decide  = tick && (cnt_q == SampC);
  assign bit_end = tick && (cnt_q == SampLast);
  // The third vote is the live sample at the decision tick.
  assign maj     = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);

  always_comb begin
    state_d = state_q;
    div_d   = tick ? DivInit : div_q - DivOne;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    brk_d   = brk_q;
    push_d  = 1'b0;
    fe_d    = 1'b0;

    if (state_q != StIdle && tick) begin
      cnt_d = (cnt_q == SampLast) ? '0 : cnt_q + SampOne;
      if (cnt_q == SampA) s0_d = rx_s;
      if (cnt_q == SampB) s1_d = rx_s;
    end

    unique case (state_q)
      StIdle: begin
        brk_d = 1'b0;
        bit_d = '0;
        if (!rx_s) begin
          // Align bit timing to the detected start edge.
          div_d   = DivInit;
          cnt_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (decide && maj) begin
          state_d = StIdle;
        end else if (bit_end) begin
          state_d = StData;
          bit_d   = '0;
        end
      end
      StData: begin
        if (decide) shift_d = {maj, shift_q[DATA_BITS-1:1]};
        if (bit_end) begin
          if (bit_q == BitLast) state_d = StStop;
          else                  bit_d   = bit_q + BitOne;
        end
      end
      StStop: begin
        if (brk_q) begin
          // Line held low past the stop bit: wait for it to return to idle.
          if (rx_s) state_d = StIdle;
        end else if (decide) begin
          if (maj) begin
            push_d  = 1'b1;
            state_d = StIdle;
          end else begin
            fe_d  = 1'b1;
            brk_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      div_q   <= DivInit;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
      brk_q   <= 1'b0;
      push_q  <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      brk_q   <= brk_d;
      push_q  <= push_d;
      fe_q    <= fe_d;
    end
  end

  assign pop          = rx_valid && rx_ready;
  assign rx_valid     = !fifo_empty;
  assign overrun      = push_q && fifo_full && !pop;
  assign frame_error  = fe_q;
  assign is_receiving = (state_q != StIdle);

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .wdata (shift_q),
    .pop   (pop),
    .rdata (rx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_uart_rx_oversampled.sv
module tb_uart_rx_oversampled;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [3:0] fifo_level;
  logic       frame_error, overrun, is_receiving;

  int checks   = 0;
  int failures = 0;

  int         fe_cnt = 0;
  int         ov_cnt = 0;
  logic [7:0] beats[$];

  uart_rx_oversampled dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .fifo_level   (fifo_level),
    .frame_error  (frame_error),
    .overrun      (overrun),
    .is_receiving (is_receiving)
  );

  always #5 clk = ~clk;

  // Observe on the falling edge: a beat here is a pop at the next rising edge.
  always @(negedge clk) begin
    if (frame_error) fe_cnt <= fe_cnt + 1;
    if (overrun)     ov_cnt <= ov_cnt + 1;
    if (rx_valid && rx_ready) beats.push_back(rx_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Defaults: one sample tick per clock, 16 clocks per bit.
  task automatic send_byte(input logic [7:0] b);
    rx = 1'b0;
    cyc(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(16);
    end
    rx = 1'b1;
    cyc(16);
  endtask

  int  fe0, ov0, nb;
  bit  seen;
  logic [7:0] v;

  initial begin
    // Reset state
    cyc(3);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_data", rx_data, 8'h00);
    check("rst_level", fifo_level, 4'd0);
    check("rst_fe", frame_error, 1'b0);
    check("rst_ov", overrun, 1'b0);
    check("rst_busy", is_receiving, 1'b0);
    rst = 1'b0;
    cyc(5);
    check("post_rst_valid", rx_valid, 1'b0);
    check("post_rst_busy", is_receiving, 1'b0);
    check("post_rst_level", fifo_level, 4'd0);

    // Single byte 0xA5
    fe0 = fe_cnt; ov0 = ov_cnt; nb = beats.size();
    send_byte(8'hA5);
    cyc(6);
    check("a5_beats", beats.size(), nb + 1);
    check("a5_data", beats[nb], 8'hA5);
    check("a5_fe", fe_cnt - fe0, 0);
    check("a5_ov", ov_cnt - ov0, 0);
    check("a5_level", fifo_level, 4'd0);
    cyc(10);

    // 5-clock glitch is a false start
    fe0 = fe_cnt; ov0 = ov_cnt; nb = beats.size();
    rx = 1'b0;
    cyc(5);
    rx = 1'b1;
    cyc(40);
    check("glitch_busy", is_receiving, 1'b0);
    check("glitch_valid", rx_valid, 1'b0);
    check("glitch_beats", beats.size(), nb);
    check("glitch_fe", fe_cnt - fe0, 0);
    check("glitch_ov", ov_cnt - ov0, 0);

    // 0x3C with stop held low for 20 bit periods, then 0x55
    fe0 = fe_cnt; nb = beats.size();
    v = 8'h3C;
    rx = 1'b0;
    cyc(16);
    for (int i = 0; i < 8; i++) begin
      rx = v[i];
      cyc(16);
    end
    rx = 1'b0;
    cyc(320);
    check("brk_busy", is_receiving, 1'b1);
    check("brk_fe", fe_cnt - fe0, 1);
    check("brk_beats", beats.size(), nb);
    rx = 1'b1;
    cyc(20);
    check("brk_idle", is_receiving, 1'b0);
    send_byte(8'h55);
    cyc(6);
    check("brk_next_beats", beats.size(), nb + 1);
    check("brk_next_data", beats[nb], 8'h55);
    check("brk_fe_once", fe_cnt - fe0, 1);
    cyc(10);

    // Fill with rx_ready=0, 9th byte overruns, then drain in order
    rx_ready = 1'b0;
    ov0 = ov_cnt;
    for (int i = 0; i < 8; i++) begin
      send_byte(8'(i));
      cyc(4);
    end
    check("full_level", fifo_level, 4'd8);
    check("full_ov_none", ov_cnt - ov0, 0);
    check("full_head", rx_data, 8'h00);
    send_byte(8'h08);
    cyc(4);
    check("ovr_pulse", ov_cnt - ov0, 1);
    check("ovr_level", fifo_level, 4'd8);
    check("ovr_head", rx_data, 8'h00);
    check("ovr_valid", rx_valid, 1'b1);
    nb = beats.size();
    rx_ready = 1'b1;
    cyc(12);
    check("drain_beats", beats.size(), nb + 8);
    for (int i = 0; i < 8; i++) check("drain_data", beats[nb + i], 32'(i));
    check("drain_level", fifo_level, 4'd0);
    check("drain_valid", rx_valid, 1'b0);

    // Full FIFO, pop on the exact push cycle
    rx_ready = 1'b0;
    ov0 = ov_cnt;
    for (int i = 0; i < 8; i++) begin
      send_byte(8'h10 + 8'(i));
      cyc(4);
    end
    check("sim_pre_level", fifo_level, 4'd8);
    nb = beats.size();
    seen = 1'b0;
    fork
      send_byte(8'h18);
      begin
        for (int i = 0; i < 400 && !seen; i++) begin
          cyc(1);
          if (is_receiving) seen = 1'b1;
        end
        check("sim_start_seen", seen, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
          cyc(1);
          if (!is_receiving) seen = 1'b1;
        end
        check("sim_end_seen", seen, 1'b1);
        // FSM leaves STOP at the decision; this cycle carries the push.
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
      end
    join
    cyc(4);
    check("sim_ov", ov_cnt - ov0, 0);
    check("sim_level", fifo_level, 4'd8);
    check("sim_one_beat", beats.size(), nb + 1);
    check("sim_first", beats[nb], 8'h10);
    rx_ready = 1'b1;
    cyc(12);
    check("sim_drain_beats", beats.size(), nb + 9);
    for (int i = 1; i < 9; i++) check("sim_order", beats[nb + i], 32'h10 + 32'(i));
    cyc(10);

    // Reset mid-DATA of 0xFF, then 0x81
    fe0 = fe_cnt; ov0 = ov_cnt; nb = beats.size();
    fork
      send_byte(8'hFF);
      begin
        cyc(60);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
      end
    join
    cyc(6);
    check("mid_rst_beats", beats.size(), nb);
    check("mid_rst_level", fifo_level, 4'd0);
    check("mid_rst_busy", is_receiving, 1'b0);
    check("mid_rst_fe", fe_cnt - fe0, 0);
    send_byte(8'h81);
    cyc(6);
    check("after_rst_beats", beats.size(), nb + 1);
    check("after_rst_data", beats[nb], 8'h81);
    check("after_rst_ov", ov_cnt - ov0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_rx_oversampled.md
UART_RX_OVERSAMPLED -- requirements
Module: uart_rx_oversampled

Interface
REQ-001 The block SHALL have parameter CLOCKFRQ, default 48_000_000, giving the clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUDRATE, default 3_000_000, giving the line rate in baud.
REQ-003 The block SHALL have parameter OVERSAMPLE, default 16, giving sample ticks per bit; it is even and at least 8.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 8, giving the byte FIFO depth; it is a power of 2.
REQ-005 Port clk: input, 1 bit, the single clock; all logic is clocked on its rising edge.
REQ-006 Port rst: input, 1 bit, synchronous active-high reset.
REQ-007 Port rx: input, 1 bit, asynchronous serial line, idle high.
REQ-008 Port rx_valid: output, 1 bit, FIFO holds at least one byte.
REQ-009 Port rx_data: output, 8 bits, FIFO head byte; valid while rx_valid=1.
REQ-010 Port rx_ready: input, 1 bit, consumer accepts the head byte.
REQ-011 Port fifo_level: output, log2(FIFO_DEPTH)+1 bits, current occupancy.
REQ-012 Port frame_error: output, 1 bit, one-cycle pulse when a stop bit is sampled low.
REQ-013 Port overrun: output, 1 bit, one-cycle pulse when a byte is dropped because the FIFO is full.
REQ-014 Port is_receiving: output, 1 bit, high whenever the state machine is not IDLE.

Function
REQ-015 rx SHALL pass through a 2-flop synchronizer whose flops reset to 1; all logic uses the synchronized value.
REQ-016 The tick divider SHALL reload with CLOCKFRQ/(BAUDRATE*OVERSAMPLE)-1 and emit a one-cycle tick when it reaches 0.
REQ-017 The state machine SHALL have four states: IDLE, START, DATA, STOP.
REQ-018 In IDLE, a synchronized low SHALL reload the divider, clear the sample counter and move to START on the next cycle.
REQ-019 Each bit SHALL be decided by 2-of-3 majority over ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1, counted from the bit start.
REQ-020 In START, a majority of 1 SHALL be treated as a false start: return to IDLE with no pulse and no FIFO write. A majority of 0 SHALL move to DATA.
REQ-021 In DATA, 8 bits SHALL be shifted in LSB first, each bit period lasting exactly OVERSAMPLE ticks.
REQ-022 In STOP with a majority of 1, the byte SHALL be pushed into the FIFO on the cycle after the decision, and the FSM SHALL return to IDLE at that decision, in mid stop bit.
REQ-023 In STOP with a majority of 0, frame_error SHALL pulse, the byte SHALL be discarded, and the FSM SHALL hold in STOP until the synchronized rx is high before entering IDLE (break handling).
REQ-024 rx_valid SHALL be !empty. rx_data SHALL be the head byte, driven combinationally from FIFO storage.
REQ-025 A pop SHALL occur when rx_valid && rx_ready. rx_data SHALL be stable while rx_valid=1 and rx_ready=0.
REQ-026 A push into a full FIFO with no pop that cycle SHALL drop the byte, pulse overrun, and leave contents unchanged.
REQ-027 A push and a pop in the same cycle SHALL both succeed, including when the FIFO is full, and fifo_level SHALL be unchanged.
REQ-028 Read and write pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap naturally. fifo_level SHALL equal wr-rd modulo 2^(width).
REQ-029 The first stored byte SHALL raise rx_valid one cycle after the push.

Reset
REQ-030 rst SHALL force: FSM to IDLE, divider to its reload value, sample counter and shift register to 0, synchronizer to 1, and FIFO pointers to 0.
REQ-031 During and after rst: rx_valid=0, rx_data=0, fifo_level=0, frame_error=0, overrun=0, is_receiving=0.
REQ-032 rst asserted mid-frame SHALL abandon the frame with no push and no pulse. A frame whose start edge precedes rst release SHALL not be received.

Structure
REQ-033 A shared package uart_pkg SHALL hold the FSM state encoding, the DATA_BITS=8 constant and the divider-computation function.
REQ-034 The FIFO SHALL be a separate sub-module uart_rx_fifo (parameter DEPTH, 8-bit data, push/pop/full/empty/level).

Verification
REQ-035 Defaults, byte 0xA5 sent at 3 Mbaud with 8N1, rx_ready=1 -> one rx_valid beat with rx_data=0xA5; frame_error=0 and overrun=0.
REQ-036 Low glitch of 5 clk on idle rx -> no FSM advance beyond START, rx_valid stays 0, no pulses.
REQ-037 Byte 0x3C with stop bit held low for 20 bit periods -> single frame_error pulse, no push, then 0x55 sent afterwards is received correctly.
REQ-038 rx_ready=0, 9 bytes 0x00..0x08 sent -> fifo_level=8 and one overrun pulse on the 9th; draining yields 0x00..0x07 in order.
REQ-039 FIFO full, rx_ready=1 on the exact cycle the next byte is pushed -> no overrun, fifo_level stays 8, byte order preserved.
REQ-040 rst asserted for 1 cycle mid-DATA of 0xFF -> no byte stored; the following 0x81 is received correctly.
